// File: rtl/mio_bus_arbiter_if.sv
// rtl/mio_bus_arbiter_if.sv - CPU/DMA master request groups and shared slave bus
interface mio_bus_arbiter_if;
   logic        cpu_req;
   logic        cpu_we;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_ready;
   logic        dma_req;
   logic        dma_we;
   logic [31:0] dma_addr;
   logic [31:0] dma_wdata;
   logic [31:0] dma_rdata;
   logic        dma_ready;
   logic        slv_req;
   logic        slv_we;
   logic [31:0] slv_addr;
   logic [31:0] slv_wdata;
   logic [31:0] slv_rdata;
   logic        slv_ack;
   logic        bus_err;
   logic [1:0]  grant;

   // Arbiter side: owns the slave strobe/command and the per-master responses.
   modport master (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  dma_req, dma_we, dma_addr, dma_wdata,
      input  slv_rdata, slv_ack,
      output cpu_rdata, cpu_ready, dma_rdata, dma_ready,
      output slv_req, slv_we, slv_addr, slv_wdata, bus_err, grant
   );

   // Environment side: requesting masters plus the slave device.
   modport slave (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output dma_req, dma_we, dma_addr, dma_wdata,
      output slv_rdata, slv_ack,
      input  cpu_rdata, cpu_ready, dma_rdata, dma_ready,
      input  slv_req, slv_we, slv_addr, slv_wdata, bus_err, grant
   );
endinterface

// File: rtl/mio_bus_arbiter.sv
// rtl/mio_bus_arbiter.sv - round-robin CPU/DMA arbiter for a single slave with ack timeout
module mio_bus_arbiter #(
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   mio_bus_arbiter_if.master bus
);
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, CPU_XFER, DMA_XFER, DONE} state_t;

   state_t        state_q, state_d;
   logic          last_dma_q, last_dma_d;   // 1: DMA was granted most recently
   logic [CW-1:0] wait_q, wait_d;
   logic          slv_we_q, slv_we_d;
   logic [31:0]   slv_addr_q, slv_addr_d;
   logic [31:0]   slv_wdata_q, slv_wdata_d;
   logic [31:0]   cpu_rdata_q, cpu_rdata_d;
   logic [31:0]   dma_rdata_q, dma_rdata_d;
   logic          cpu_ready_q, cpu_ready_d;
   logic          dma_ready_q, dma_ready_d;
   logic          bus_err_q, bus_err_d;
   logic          cpu_wins;

   // CPU takes a tie only when DMA held the previous grant.
   assign cpu_wins = bus.cpu_req && (!bus.dma_req || last_dma_q);

   // State register and all registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         last_dma_q  <= 1'b1;
         wait_q      <= '0;
         slv_we_q    <= 1'b0;
         slv_addr_q  <= '0;
         slv_wdata_q <= '0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
         cpu_ready_q <= 1'b0;
         dma_ready_q <= 1'b0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_dma_q  <= last_dma_d;
         wait_q      <= wait_d;
         slv_we_q    <= slv_we_d;
         slv_addr_q  <= slv_addr_d;
         slv_wdata_q <= slv_wdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         dma_rdata_q <= dma_rdata_d;
         cpu_ready_q <= cpu_ready_d;
         dma_ready_q <= dma_ready_d;
         bus_err_q   <= bus_err_d;
      end
   end

   // Arbitration, command latching, ack/timeout completion.
   always_comb begin
      state_d     = state_q;
      last_dma_d  = last_dma_q;
      wait_d      = wait_q;
      slv_we_d    = slv_we_q;
      slv_addr_d  = slv_addr_q;
      slv_wdata_d = slv_wdata_q;
      cpu_rdata_d = cpu_rdata_q;
      dma_rdata_d = dma_rdata_q;
      cpu_ready_d = 1'b0;
      dma_ready_d = 1'b0;
      bus_err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            wait_d = '0;
            if (cpu_wins) begin
               state_d     = CPU_XFER;
               last_dma_d  = 1'b0;
               slv_we_d    = bus.cpu_we;
               slv_addr_d  = bus.cpu_addr;
               slv_wdata_d = bus.cpu_wdata;
            end else if (bus.dma_req) begin
               state_d     = DMA_XFER;
               last_dma_d  = 1'b1;
               slv_we_d    = bus.dma_we;
               slv_addr_d  = bus.dma_addr;
               slv_wdata_d = bus.dma_wdata;
            end
         end
         CPU_XFER, DMA_XFER: begin
            // Ack is checked first so it wins over a same-cycle timeout.
            if (bus.slv_ack) begin
               state_d = DONE;
               if (state_q == CPU_XFER) begin
                  cpu_rdata_d = bus.slv_rdata;
                  cpu_ready_d = 1'b1;
               end else begin
                  dma_rdata_d = bus.slv_rdata;
                  dma_ready_d = 1'b1;
               end
            end else if (wait_q == LAST_WAIT) begin
               state_d     = DONE;
               bus_err_d   = 1'b1;
               cpu_ready_d = (state_q == CPU_XFER);
               dma_ready_d = (state_q == DMA_XFER);
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.slv_req   = (state_q == CPU_XFER) || (state_q == DMA_XFER);
   assign bus.grant     = (state_q == CPU_XFER) ? 2'b01 :
                          (state_q == DMA_XFER) ? 2'b10 : 2'b00;
   assign bus.slv_we    = slv_we_q;
   assign bus.slv_addr  = slv_addr_q;
   assign bus.slv_wdata = slv_wdata_q;
   assign bus.cpu_rdata = cpu_rdata_q;
   assign bus.dma_rdata = dma_rdata_q;
   assign bus.cpu_ready = cpu_ready_q;
   assign bus.dma_ready = dma_ready_q;
   assign bus.bus_err   = bus_err_q;
endmodule

// File: doc/mio_bus_arbiter.md
MIO_BUS_ARBITER -- requirements
Module: mio_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum number of cycles a granted transfer waits for slv_ack before it is aborted.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 cpu_req  in  1  CPU transfer request (MemRead|MemWrite); held high until cpu_ready.
REQ-005 cpu_we  in  1  CPU write enable (1 = write).
REQ-006 cpu_addr  in  32  CPU byte address.
REQ-007 cpu_wdata  in  32  CPU write data.
REQ-008 cpu_rdata  out  32  registered read data to CPU.
REQ-009 cpu_ready  out  1  one-cycle completion pulse to CPU (drives MIO_ready).
REQ-010 dma_req, dma_we, dma_addr[31:0], dma_wdata[31:0]  in  DMA-master request group; same meaning as the CPU group.
REQ-011 dma_rdata  out  32; dma_ready  out  1  DMA read data and completion pulse.
REQ-012 slv_req  out  1  slave access strobe; held high for the whole granted transfer.
REQ-013 slv_we  out  1; slv_addr  out  32; slv_wdata  out  32  latched command to the slave.
REQ-014 slv_rdata  in  32; slv_ack  in  1  slave read data and one-cycle completion.
REQ-015 bus_err  out  1  one-cycle pulse on timeout abort, coincident with the ready pulse.
REQ-016 grant  out  2  status: 00 idle, 01 CPU, 10 DMA.

Function
REQ-017 FSM states SHALL be IDLE, CPU_XFER, DMA_XFER, DONE.
REQ-018 In IDLE with exactly one request high, the FSM SHALL enter that master's XFER state on the next edge.
REQ-019 In IDLE with both requests high, the master not granted last SHALL win (round-robin); after reset, the last-grant bit SHALL indicate DMA, so the CPU wins the first tie.
REQ-020 On the IDLE->XFER edge, the winner's we, addr and wdata SHALL be latched into slv_we, slv_addr and slv_wdata, which SHALL remain stable throughout XFER.
REQ-021 slv_req SHALL be 1 exactly while in CPU_XFER or DMA_XFER.
REQ-022 In XFER, a cycle with slv_ack=1 SHALL:
  - capture slv_rdata into the granted master's rdata register;
  - pulse that master's ready for one cycle on the next edge;
  - move the FSM to DONE.
REQ-023 Minimum latency: request high in IDLE at cycle 0, slv_ack at cycle 1 -> ready high at cycle 2.
REQ-024 A wait counter SHALL clear on entry to XFER and increment each XFER cycle without ack.
REQ-025 If the wait counter reaches TIMEOUT-1 without ack, the FSM SHALL enter DONE, pulse ready and bus_err together, and leave rdata unchanged.
REQ-026 Ack and timeout in the same cycle: ack SHALL take precedence and bus_err SHALL stay 0.
REQ-027 DONE SHALL last one cycle with slv_req=0 and no arbitration, then return to IDLE.
  - A requester that keeps req high after its ready is treated as a new request.
  - No master is granted twice back-to-back while the other master is waiting.
REQ-028 slv_ack received in IDLE or DONE SHALL be ignored.
REQ-029 The non-granted master's ready SHALL stay 0, and its rdata SHALL hold its last value.
REQ-030 Requests are level-sensitive: a req dropped before its grant is simply not served; a req dropped during XFER SHALL NOT abort the transfer.
REQ-031 grant SHALL reflect the current state combinationally (01 in CPU_XFER, 10 in DMA_XFER, else 00).

Reset
REQ-032 On reset:
  - state IDLE; last-grant = DMA; wait counter 0;
  - slv_req, slv_we, cpu_ready, dma_ready, bus_err = 0;
  - slv_addr, slv_wdata, cpu_rdata, dma_rdata = 0.
REQ-033 Reset asserted mid-transfer SHALL abort immediately with no ready pulse; after release, the FSM SHALL restart arbitration from IDLE.

Verification
REQ-034 CPU read only: cpu_req=1, cpu_addr=0x100, slave acks the next cycle with 0xDEADBEEF -> slv_addr=0x100, cpu_rdata=0xDEADBEEF, cpu_ready pulse at cycle 2, grant 01 then 00.
REQ-035 Both masters requesting continuously, slave acks every cycle -> grants alternate CPU, DMA, CPU, DMA, with one DONE cycle between grants and the CPU first after reset.
REQ-036 DMA write 0x55AA to 0x2000, slave never acks, TIMEOUT=16 -> slv_req high for 16 cycles, then dma_ready=1 and bus_err=1 for one cycle, dma_rdata unchanged.
REQ-037 Ack asserted on the exact timeout cycle -> ready=1, bus_err=0, rdata captured.
REQ-038 Reset asserted during CPU_XFER after 3 wait cycles -> slv_req=0 and cpu_ready never pulses; a new request after release is served normally.
REQ-039 cpu_addr changed during XFER, and a spurious slv_ack in IDLE -> slv_addr holds the latched value; the spurious ack produces no ready.
